// File: rtl/adc_frame_align.sv
// Word-boundary alignment and 12-bit sample assembly for one ADC lane pair.
// Optional test-pattern error counter enabled by defining ADC_ALIGN_TESTPAT_EN.
module adc_frame_align #(
   parameter int unsigned SETTLE   = 4,
   parameter int unsigned MAX_SLIP = 12,
   parameter int unsigned LOSS_THR = 4
`ifdef ADC_ALIGN_TESTPAT_EN
   ,
   parameter logic [11:0] TESTPAT  = 12'hA5C
`endif
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [5:0]  FRAME,
   input  logic [5:0]  DIN,
   output logic        BS,
   output logic        LOCKED,
   output logic        ALIGN_ERR,
   output logic [11:0] SAMPLE,
   output logic        VALID,
   output logic [15:0] ERRCNT
);

   localparam int unsigned WAIT_W = (SETTLE   > 1) ? $clog2(SETTLE + 1)   : 1;
   localparam int unsigned SLIP_W = (MAX_SLIP > 1) ? $clog2(MAX_SLIP + 1) : 1;
   localparam int unsigned MISS_W = (LOSS_THR > 1) ? $clog2(LOSS_THR + 1) : 1;
   localparam logic [5:0]  W_ONES  = 6'h3F;
   localparam logic [5:0]  W_ZEROS = 6'h00;

   typedef enum logic [2:0] {
      S_WAIT,
      S_CHECK_A,
      S_CHECK_B,
      S_SLIP,
      S_LOCK
   } state_e;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
   logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
   logic [5:0]          w0_q, w0_d;
   logic [5:0]          exp_q, exp_d;
   logic [5:0]          hi_q, hi_d;
   logic                hi_vld_q, hi_vld_d;
   logic                bs_q, bs_d;
   logic                locked_q, locked_d;
   logic                align_err_q, align_err_d;
   logic [11:0]         sample_q, sample_d;
   logic                valid_q, valid_d;

   // Next-state, slip search, lock monitor and sample assembly
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      slip_cnt_d  = slip_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      w0_d        = w0_q;
      exp_d       = exp_q;
      hi_d        = hi_q;
      hi_vld_d    = 1'b0;
      bs_d        = 1'b0;
      locked_d    = locked_q;
      align_err_d = align_err_q;
      sample_d    = sample_q;
      valid_d     = 1'b0;

      case (state_q)
         S_WAIT: begin
            if (wait_cnt_q == WAIT_W'(SETTLE - 1)) begin
               wait_cnt_d = '0;
               state_d    = S_CHECK_A;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         S_CHECK_A: begin
            if (FRAME == W_ONES || FRAME == W_ZEROS) begin
               w0_d    = FRAME;
               state_d = S_CHECK_B;
            end else begin
               bs_d    = 1'b1;
               state_d = S_SLIP;
            end
         end

         S_CHECK_B: begin
            if (FRAME == ~w0_q) begin
               // Next word expected to repeat W0 since the lane toggles each word
               state_d    = S_LOCK;
               locked_d   = 1'b1;
               slip_cnt_d = '0;
               miss_cnt_d = '0;
               exp_d      = w0_q;
            end else begin
               bs_d    = 1'b1;
               state_d = S_SLIP;
            end
         end

         S_SLIP: begin
            if (slip_cnt_q == SLIP_W'(MAX_SLIP - 1)) begin
               align_err_d = 1'b1;
               slip_cnt_d  = '0;
            end else begin
               slip_cnt_d = slip_cnt_q + SLIP_W'(1);
            end
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end

         S_LOCK: begin
            exp_d = ~exp_q;
            if (FRAME == exp_q) begin
               miss_cnt_d = '0;
               if (FRAME == W_ONES) begin
                  hi_d     = DIN;
                  hi_vld_d = 1'b1;
               end else if (hi_vld_q) begin
                  sample_d = {hi_q, DIN};
                  valid_d  = 1'b1;
               end
            end else if (miss_cnt_q == MISS_W'(LOSS_THR - 1)) begin
               // Lock lost: re-check in place, the slip position is presumed still good
               miss_cnt_d = '0;
               locked_d   = 1'b0;
               state_d    = S_CHECK_A;
            end else begin
               miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
         end

         default: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_WAIT;
         wait_cnt_q  <= '0;
         slip_cnt_q  <= '0;
         miss_cnt_q  <= '0;
         w0_q        <= '0;
         exp_q       <= '0;
         hi_q        <= '0;
         hi_vld_q    <= 1'b0;
         bs_q        <= 1'b0;
         locked_q    <= 1'b0;
         align_err_q <= 1'b0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         slip_cnt_q  <= slip_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         w0_q        <= w0_d;
         exp_q       <= exp_d;
         hi_q        <= hi_d;
         hi_vld_q    <= hi_vld_d;
         bs_q        <= bs_d;
         locked_q    <= locked_d;
         align_err_q <= align_err_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
      end
   end

   assign BS        = bs_q;
   assign LOCKED    = locked_q;
   assign ALIGN_ERR = align_err_q;
   assign SAMPLE    = sample_q;
   assign VALID     = valid_q;

`ifdef ADC_ALIGN_TESTPAT_EN
   logic [15:0] errcnt_q, errcnt_d;

   // Saturating count of delivered samples that differ from the test pattern
   always_comb begin
      errcnt_d = errcnt_q;
      if (valid_q && (sample_q != TESTPAT) && (errcnt_q != 16'hFFFF)) begin
         errcnt_d = errcnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         errcnt_q <= '0;
      end else begin
         errcnt_q <= errcnt_d;
      end
   end

   assign ERRCNT = errcnt_q;
`else
   assign ERRCNT = '0;
`endif

endmodule
